tx_multi_vc: RTL and testbench
==============================

Name: tx_multi_vc

Overview:
Parametrised transmit-side flow-control block. Words enter a main FIFO, are steered by header bits into NUM_VC virtual-channel FIFOs, then arbitrated into NUM_DEST destination FIFOs that downstream logic pops. It generalises the fixed 2-VC/2-destination transmit path: widths, depths, VC count, destination count and threshold behaviour are all configurable. It also adds MAIN_PAUSE hysteresis, selectable arbitration, an explicit state machine and a sticky overflow error.

Parameters:
DATA_W, 6, word width; bits [DATA_W-1 -: VC_SEL_W] select the VC, and the next DEST_SEL_W bits select the destination.
NUM_VC, 2, number of VC FIFOs; a power of two, at least 2; VC_SEL_W = log2(NUM_VC).
NUM_DEST, 2, number of destination FIFOs; a power of two, at least 2; DEST_SEL_W = log2(NUM_DEST).
MAIN_DEPTH, 8, main FIFO depth; a power of two.
VC_DEPTH, 4, depth of each VC FIFO.
DEST_DEPTH, 4, depth of each destination FIFO.
CNT_W, 4, occupancy counter and threshold width; must hold the largest depth.

Ports:
clk  in  1  clock; all logic is on the rising edge.
RESET_L  in  1  asynchronous active-low reset.
init  in  1  threshold-load request.
PUSH_MAIN  in  1  write DATA_IN_TX into the main FIFO.
DATA_IN_TX  in  DATA_W  input word.
POP_D  in  NUM_DEST  per-destination pop request.
main_fifo_low  in  CNT_W  MAIN_PAUSE release threshold.
main_fifo_high  in  CNT_W  MAIN_PAUSE assert threshold.
vc_high  in  NUM_VC*CNT_W  per-VC almost-full threshold, packed.
dest_low  in  NUM_DEST*CNT_W  per-destination almost-empty threshold, packed.
dest_high  in  NUM_DEST*CNT_W  per-destination almost-full threshold, packed.
DATA_OUT_D  out  NUM_DEST*DATA_W  registered pop data, packed.
VALID_D  out  NUM_DEST  DATA_OUT_D slice is valid this cycle.
EMPTY_D  out  NUM_DEST  destination FIFO empty.
ALMOST_EMPTY_D  out  NUM_DEST  destination count <= dest_low.
MAIN_PAUSE  out  1  backpressure to the upstream source.
STATE  out  3  FSM state.
IDLE_OUT  out  1  STATE==IDLE.
ERROR_OUT  out  1  sticky overflow flag.

Behaviour:
- Reset (RESET_L=0, asynchronous): all FIFOs are emptied and all counters cleared; STATE=RESET(0); every output is 0 except EMPTY_D, which is all ones; latched thresholds are cleared.
- FSM encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
  - RESET->INIT on the first edge after reset release.
  - INIT: thresholds are latched every cycle; INIT->IDLE when init=0.
  - IDLE->INIT when init=1.
  - IDLE<->ACTIVE: ACTIVE whenever any FIFO is non-empty, IDLE when all are empty.
  - ACTIVE does not honour init.
  - Any state except RESET goes to ERROR on overflow. ERROR is sticky until RESET_L=0.
- Pushes and transfers occur only in IDLE or ACTIVE. In RESET, INIT and ERROR, PUSH_MAIN is ignored and internal transfers stall. Pops are served in every state except RESET.
- Main->VC transfer: at most one per cycle. The main FIFO head moves when main is non-empty and the target VC count < its latched vc_high.
- VC->dest transfer: at most one per cycle. Eligible VCs are those that are non-empty and whose head's destination count < its dest_high. The arbiter selects one eligible VC.
- Latency: a word written at edge N moves to its VC at edge N+1 and to its destination at N+2, so EMPTY_D goes low after N+2 (absent blocking). POP_D at edge N+3 gives DATA_OUT_D and VALID_D=1 after N+3.
- Pop on empty: ignored; VALID_D=0 and DATA_OUT_D holds its previous value; no error.
- Overflow: PUSH_MAIN while main is full drops the word, sets ERROR_OUT=1 and moves STATE to ERROR. Internal transfers never overflow because they are threshold-gated and also gated on not-full.
- Simultaneous push and pop on the same FIFO: both occur and the count is unchanged; for the main FIFO when full, a same-cycle pop frees the slot, so no overflow.
- Counters are unsigned CNT_W-bit; pointers wrap modulo depth.
- MAIN_PAUSE is registered:
  - set when main count >= main_fifo_high;
  - cleared when count <= main_fifo_low;
  - otherwise held.
- ALMOST_EMPTY_D is combinational from the counts.

Optional Feature:
TX_RR_ARB_EN: when defined, the VC->dest arbiter is round-robin. The pointer advances to the VC after the last winner, and it resets to VC0. When undefined, the arbiter is fixed priority with the lowest-index eligible VC winning.

Test Plan:
1. RESET_L=0, then release with init=1, main_fifo_high=6, main_fifo_low=2 -> outputs 0 and EMPTY_D=2'b11 during reset; STATE 0->1; init=0 -> STATE=2 and IDLE_OUT=1.
2. From IDLE, push 6'h15 (VC0, dest1) at edge N, pop D1 at N+3 -> EMPTY_D[1]=0 after N+2; DATA_OUT_D1=6'h15 and VALID_D[1]=1 after N+3; STATE returns to IDLE.
3. vc_high=1, dest_high=1, push 8 words to VC0/dest0 with no pops -> MAIN_PAUSE=1 once main count reaches 6; then pulse POP_D0 repeatedly -> MAIN_PAUSE=0 only after main count <= 2.
4. With TX_RR_ARB_EN defined, preload VC0={0x01,0x03} and VC1={0x21,0x23}, all to dest0 -> dest0 order is 0x01,0x21,0x03,0x23. Without the macro the order is 0x01,0x03,0x21,0x23.
5. vc_high=0 (main blocked), push 9 words -> ninth word dropped, ERROR_OUT=1, STATE=4, further pushes ignored; RESET_L=0 clears everything.
6. POP_D0 on empty dest0 -> VALID_D[0]=0 and DATA_OUT_D0 unchanged; ERROR_OUT stays 0.

Source files
------------

// File: rtl/tx_multi_vc.sv
// tx_multi_vc: transmit-side flow control. Words enter a main FIFO, are steered by
// their header into NUM_VC virtual-channel FIFOs, then arbitrated into NUM_DEST
// destination FIFOs popped by downstream logic. Each hop is gated by a latched
// threshold, MAIN_PAUSE gives hysteretic backpressure, and overflow is sticky.
// Optional macro TX_RR_ARB_EN: round-robin VC->dest arbitration; when undefined the
// lowest-index eligible VC wins.
module tx_multi_vc #(
  parameter int DATA_W     = 6,
  parameter int NUM_VC     = 2,
  parameter int NUM_DEST   = 2,
  parameter int MAIN_DEPTH = 8,
  parameter int VC_DEPTH   = 4,
  parameter int DEST_DEPTH = 4,
  parameter int CNT_W      = 4
) (
  input  logic                         clk,
  input  logic                         RESET_L,
  input  logic                         init,
  input  logic                         PUSH_MAIN,
  input  logic [DATA_W-1:0]            DATA_IN_TX,
  input  logic [NUM_DEST-1:0]          POP_D,
  input  logic [CNT_W-1:0]             main_fifo_low,
  input  logic [CNT_W-1:0]             main_fifo_high,
  input  logic [NUM_VC*CNT_W-1:0]      vc_high,
  input  logic [NUM_DEST*CNT_W-1:0]    dest_low,
  input  logic [NUM_DEST*CNT_W-1:0]    dest_high,
  output logic [NUM_DEST*DATA_W-1:0]   DATA_OUT_D,
  output logic [NUM_DEST-1:0]          VALID_D,
  output logic [NUM_DEST-1:0]          EMPTY_D,
  output logic [NUM_DEST-1:0]          ALMOST_EMPTY_D,
  output logic                         MAIN_PAUSE,
  output logic [2:0]                   STATE,
  output logic                         IDLE_OUT,
  output logic                         ERROR_OUT
);

  localparam int VC_SEL_W   = $clog2(NUM_VC);
  localparam int DEST_SEL_W = $clog2(NUM_DEST);
  localparam int MAIN_PTR_W = (MAIN_DEPTH > 1) ? $clog2(MAIN_DEPTH) : 1;
  localparam int VC_PTR_W   = (VC_DEPTH > 1) ? $clog2(VC_DEPTH) : 1;
  localparam int DEST_PTR_W = (DEST_DEPTH > 1) ? $clog2(DEST_DEPTH) : 1;

  localparam logic [CNT_W-1:0]      MAIN_FULL = CNT_W'(MAIN_DEPTH);
  localparam logic [CNT_W-1:0]      VC_FULL   = CNT_W'(VC_DEPTH);
  localparam logic [CNT_W-1:0]      DEST_FULL = CNT_W'(DEST_DEPTH);
  localparam logic [MAIN_PTR_W-1:0] MAIN_LAST = MAIN_PTR_W'(MAIN_DEPTH - 1);
  localparam logic [VC_PTR_W-1:0]   VC_LAST   = VC_PTR_W'(VC_DEPTH - 1);
  localparam logic [DEST_PTR_W-1:0] DEST_LAST = DEST_PTR_W'(DEST_DEPTH - 1);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  state_e state_q;
  logic   error_q;
  logic   pause_q;
  logic   pause_d;

  // Latched thresholds
  logic [CNT_W-1:0] mainLow_q;
  logic [CNT_W-1:0] mainHigh_q;
  logic [CNT_W-1:0] vcHigh_q   [NUM_VC];
  logic [CNT_W-1:0] destLow_q  [NUM_DEST];
  logic [CNT_W-1:0] destHigh_q [NUM_DEST];

  // Main FIFO
  logic [DATA_W-1:0]     mainMem_q [MAIN_DEPTH];
  logic [MAIN_PTR_W-1:0] mainWr_q;
  logic [MAIN_PTR_W-1:0] mainRd_q;
  logic [CNT_W-1:0]      mainCnt_q;

  // VC FIFOs
  logic [DATA_W-1:0]   vcMem_q [NUM_VC][VC_DEPTH];
  logic [VC_PTR_W-1:0] vcWr_q  [NUM_VC];
  logic [VC_PTR_W-1:0] vcRd_q  [NUM_VC];
  logic [CNT_W-1:0]    vcCnt_q [NUM_VC];

  // Destination FIFOs and registered pop outputs
  logic [DATA_W-1:0]     destMem_q [NUM_DEST][DEST_DEPTH];
  logic [DEST_PTR_W-1:0] destWr_q  [NUM_DEST];
  logic [DEST_PTR_W-1:0] destRd_q  [NUM_DEST];
  logic [CNT_W-1:0]      destCnt_q [NUM_DEST];
  logic [DATA_W-1:0]     dataOut_q [NUM_DEST];
  logic [NUM_DEST-1:0]   valid_q;

  logic                  runEn;
  logic                  anyNonEmpty;
  logic [DATA_W-1:0]     mainHead;
  logic [VC_SEL_W-1:0]   mainVc;
  logic                  mainToVc;
  logic                  pushAccept;
  logic                  overflow;
  logic [DATA_W-1:0]     vcHead [NUM_VC];
  logic [DEST_SEL_W-1:0] vcDest [NUM_VC];
  logic [NUM_VC-1:0]     eligible;
  logic                  grantValid;
  logic [VC_SEL_W-1:0]   grantVc;
  logic [DEST_SEL_W-1:0] grantDest;
  logic [DATA_W-1:0]     grantData;
  logic [NUM_DEST-1:0]   destPop;

  // Pushes and internal transfers only move while the block is operational
  assign runEn = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);

  // Main FIFO head steering and overflow detection; a same-cycle move frees the slot
  always_comb begin
    mainHead   = mainMem_q[mainRd_q];
    mainVc     = mainHead[DATA_W-1 -: VC_SEL_W];
    mainToVc   = runEn && (mainCnt_q != '0) &&
                 (vcCnt_q[mainVc] < vcHigh_q[mainVc]) && (vcCnt_q[mainVc] != VC_FULL);
    pushAccept = PUSH_MAIN && runEn && ((mainCnt_q != MAIN_FULL) || mainToVc);
    overflow   = PUSH_MAIN && runEn && (mainCnt_q == MAIN_FULL) && !mainToVc;
  end

  // VC eligibility: non-empty and the head's destination is below its threshold and not full
  always_comb begin
    eligible = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      vcHead[v]   = vcMem_q[v][vcRd_q[v]];
      vcDest[v]   = vcHead[v][DATA_W-1-VC_SEL_W -: DEST_SEL_W];
      eligible[v] = runEn && (vcCnt_q[v] != '0) &&
                    (destCnt_q[vcDest[v]] < destHigh_q[vcDest[v]]) &&
                    (destCnt_q[vcDest[v]] != DEST_FULL);
    end
  end

`ifdef TX_RR_ARB_EN
  logic [VC_SEL_W-1:0] rrPtr_q;

  // Round-robin: search starts at the VC after the previous winner
  always_comb begin
    logic [VC_SEL_W-1:0] idx;
    grantValid = 1'b0;
    grantVc    = '0;
    idx        = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      idx = rrPtr_q + VC_SEL_W'(i);
      if (!grantValid && eligible[idx]) begin
        grantValid = 1'b1;
        grantVc    = idx;
      end
    end
  end

  // Round-robin pointer moves past each winner
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) rrPtr_q <= '0;
    else if (grantValid) rrPtr_q <= grantVc + 1'b1;
  end
`else
  // Fixed priority: the lowest-index eligible VC wins
  always_comb begin
    grantValid = 1'b0;
    grantVc    = '0;
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        grantValid = 1'b1;
        grantVc    = VC_SEL_W'(i);
      end
    end
  end
`endif

  assign grantDest = vcDest[grantVc];
  assign grantData = vcHead[grantVc];

  // Destination pops are served in every state except RESET, and only when data exists
  always_comb begin
    for (int d = 0; d < NUM_DEST; d++)
      destPop[d] = POP_D[d] && (state_q != ST_RESET) && (destCnt_q[d] != '0);
  end

  // Any occupied FIFO keeps the FSM in ACTIVE
  always_comb begin
    anyNonEmpty = (mainCnt_q != '0);
    for (int v = 0; v < NUM_VC; v++)
      if (vcCnt_q[v] != '0) anyNonEmpty = 1'b1;
    for (int d = 0; d < NUM_DEST; d++)
      if (destCnt_q[d] != '0) anyNonEmpty = 1'b1;
  end

  // Thresholds track the inputs only while in INIT
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      mainLow_q  <= '0;
      mainHigh_q <= '0;
      for (int v = 0; v < NUM_VC; v++) vcHigh_q[v] <= '0;
      for (int d = 0; d < NUM_DEST; d++) begin
        destLow_q[d]  <= '0;
        destHigh_q[d] <= '0;
      end
    end else if (state_q == ST_INIT) begin
      mainLow_q  <= main_fifo_low;
      mainHigh_q <= main_fifo_high;
      for (int v = 0; v < NUM_VC; v++) vcHigh_q[v] <= vc_high[v*CNT_W +: CNT_W];
      for (int d = 0; d < NUM_DEST; d++) begin
        destLow_q[d]  <= dest_low[d*CNT_W +: CNT_W];
        destHigh_q[d] <= dest_high[d*CNT_W +: CNT_W];
      end
    end
  end

  // Main FIFO storage
  always_ff @(posedge clk) begin
    if (pushAccept) mainMem_q[mainWr_q] <= DATA_IN_TX;
  end

  // Main FIFO pointers and occupancy
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      mainWr_q  <= '0;
      mainRd_q  <= '0;
      mainCnt_q <= '0;
    end else begin
      if (pushAccept) mainWr_q <= (mainWr_q == MAIN_LAST) ? '0 : mainWr_q + 1'b1;
      if (mainToVc)   mainRd_q <= (mainRd_q == MAIN_LAST) ? '0 : mainRd_q + 1'b1;
      if (pushAccept && !mainToVc)      mainCnt_q <= mainCnt_q + 1'b1;
      else if (!pushAccept && mainToVc) mainCnt_q <= mainCnt_q - 1'b1;
    end
  end

  // VC FIFO storage
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++)
      if (mainToVc && (mainVc == VC_SEL_W'(v))) vcMem_q[v][vcWr_q[v]] <= mainHead;
  end

  // VC FIFO pointers and occupancy
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      for (int v = 0; v < NUM_VC; v++) begin
        vcWr_q[v]  <= '0;
        vcRd_q[v]  <= '0;
        vcCnt_q[v] <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        logic psh, pp;
        psh = mainToVc && (mainVc == VC_SEL_W'(v));
        pp  = grantValid && (grantVc == VC_SEL_W'(v));
        if (psh) vcWr_q[v] <= (vcWr_q[v] == VC_LAST) ? '0 : vcWr_q[v] + 1'b1;
        if (pp)  vcRd_q[v] <= (vcRd_q[v] == VC_LAST) ? '0 : vcRd_q[v] + 1'b1;
        if (psh && !pp)      vcCnt_q[v] <= vcCnt_q[v] + 1'b1;
        else if (!psh && pp) vcCnt_q[v] <= vcCnt_q[v] - 1'b1;
      end
    end
  end

  // Destination FIFO storage
  always_ff @(posedge clk) begin
    for (int d = 0; d < NUM_DEST; d++)
      if (grantValid && (grantDest == DEST_SEL_W'(d))) destMem_q[d][destWr_q[d]] <= grantData;
  end

  // Destination pointers, occupancy and registered pop data; DATA_OUT holds on idle pops
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      valid_q <= '0;
      for (int d = 0; d < NUM_DEST; d++) begin
        destWr_q[d]  <= '0;
        destRd_q[d]  <= '0;
        destCnt_q[d] <= '0;
        dataOut_q[d] <= '0;
      end
    end else begin
      valid_q <= destPop;
      for (int d = 0; d < NUM_DEST; d++) begin
        logic psh;
        psh = grantValid && (grantDest == DEST_SEL_W'(d));
        if (psh) destWr_q[d] <= (destWr_q[d] == DEST_LAST) ? '0 : destWr_q[d] + 1'b1;
        if (destPop[d]) begin
          destRd_q[d]  <= (destRd_q[d] == DEST_LAST) ? '0 : destRd_q[d] + 1'b1;
          dataOut_q[d] <= destMem_q[d][destRd_q[d]];
        end
        if (psh && !destPop[d])      destCnt_q[d] <= destCnt_q[d] + 1'b1;
        else if (!psh && destPop[d]) destCnt_q[d] <= destCnt_q[d] - 1'b1;
      end
    end
  end

  // MAIN_PAUSE hysteresis; held low until thresholds have been loaded
  always_comb begin
    pause_d = pause_q;
    if ((state_q == ST_RESET) || (state_q == ST_INIT)) pause_d = 1'b0;
    else if (mainCnt_q >= mainHigh_q)                  pause_d = 1'b1;
    else if (mainCnt_q <= mainLow_q)                   pause_d = 1'b0;
  end

  // MAIN_PAUSE register
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) pause_q <= 1'b0;
    else          pause_q <= pause_d;
  end

  // Control FSM with sticky error; only a reset leaves ERROR
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q <= ST_RESET;
      error_q <= 1'b0;
    end else begin
      if (overflow) error_q <= 1'b1;
      case (state_q)
        ST_RESET:  state_q <= ST_INIT;
        ST_INIT:   if (!init) state_q <= ST_IDLE;
        ST_IDLE: begin
          if (overflow)         state_q <= ST_ERROR;
          else if (init)        state_q <= ST_INIT;
          else if (anyNonEmpty) state_q <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (overflow)          state_q <= ST_ERROR;
          else if (!anyNonEmpty) state_q <= ST_IDLE;
        end
        ST_ERROR:  state_q <= ST_ERROR;
        default:   state_q <= ST_RESET;
      endcase
    end
  end

  // Output mapping; ALMOST_EMPTY_D stays low in RESET so the reset state reads all-zero
  always_comb begin
    for (int d = 0; d < NUM_DEST; d++) begin
      DATA_OUT_D[d*DATA_W +: DATA_W] = dataOut_q[d];
      EMPTY_D[d]        = (destCnt_q[d] == '0);
      ALMOST_EMPTY_D[d] = (state_q != ST_RESET) && (destCnt_q[d] <= destLow_q[d]);
    end
  end

  assign VALID_D    = valid_q;
  assign MAIN_PAUSE = pause_q;
  assign STATE      = state_q;
  assign IDLE_OUT   = (state_q == ST_IDLE);
  assign ERROR_OUT  = error_q;

endmodule

// File: tb/tb_tx_multi_vc.sv
// tb_tx_multi_vc: directed self-checking bench for tx_multi_vc with default parameters.
module tb_tx_multi_vc;

  logic        clk = 1'b0;
  logic        RESET_L;
  logic        init;
  logic        PUSH_MAIN;
  logic [5:0]  DATA_IN_TX;
  logic [1:0]  POP_D;
  logic [3:0]  main_fifo_low;
  logic [3:0]  main_fifo_high;
  logic [7:0]  vc_high;
  logic [7:0]  dest_low;
  logic [7:0]  dest_high;
  logic [11:0] DATA_OUT_D;
  logic [1:0]  VALID_D;
  logic [1:0]  EMPTY_D;
  logic [1:0]  ALMOST_EMPTY_D;
  logic        MAIN_PAUSE;
  logic [2:0]  STATE;
  logic        IDLE_OUT;
  logic        ERROR_OUT;

  int checksTotal  = 0;
  int checksPassed = 0;

  tx_multi_vc dut (
    .clk            (clk),
    .RESET_L        (RESET_L),
    .init           (init),
    .PUSH_MAIN      (PUSH_MAIN),
    .DATA_IN_TX     (DATA_IN_TX),
    .POP_D          (POP_D),
    .main_fifo_low  (main_fifo_low),
    .main_fifo_high (main_fifo_high),
    .vc_high        (vc_high),
    .dest_low       (dest_low),
    .dest_high      (dest_high),
    .DATA_OUT_D     (DATA_OUT_D),
    .VALID_D        (VALID_D),
    .EMPTY_D        (EMPTY_D),
    .ALMOST_EMPTY_D (ALMOST_EMPTY_D),
    .MAIN_PAUSE     (MAIN_PAUSE),
    .STATE          (STATE),
    .IDLE_OUT       (IDLE_OUT),
    .ERROR_OUT      (ERROR_OUT)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walk IDLE -> INIT -> IDLE so the current threshold inputs get latched
  task automatic reinit();
    init = 1'b1;
    tick();
    init = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    RESET_L = 1'b0; init = 1'b1; PUSH_MAIN = 1'b0; DATA_IN_TX = '0; POP_D = '0;
    main_fifo_high = 4'd6; main_fifo_low = 4'd2;
    vc_high = 8'h44; dest_low = 8'h11; dest_high = 8'h44;
    repeat (2) tick();
    checksTotal++;
    if (STATE !== 3'd0) $display("[TB] FAIL reset_state: got %0d expected 0", STATE);
    else checksPassed++;
    checksTotal++;
    if (EMPTY_D !== 2'b11) $display("[TB] FAIL reset_empty: got %b expected 11", EMPTY_D);
    else checksPassed++;
    checksTotal++;
    if ({DATA_OUT_D, VALID_D, ALMOST_EMPTY_D, MAIN_PAUSE, IDLE_OUT, ERROR_OUT} !== '0)
      $display("[TB] FAIL reset_outputs: got %h/%b/%b/%b/%b/%b expected all zero",
               DATA_OUT_D, VALID_D, ALMOST_EMPTY_D, MAIN_PAUSE, IDLE_OUT, ERROR_OUT);
    else checksPassed++;
    @(negedge clk);
    RESET_L = 1'b1;
    tick();
    checksTotal++;
    if (STATE !== 3'd1) $display("[TB] FAIL state_init: got %0d expected 1", STATE);
    else checksPassed++;
    tick();
    checksTotal++;
    if (STATE !== 3'd1) $display("[TB] FAIL state_init_hold: got %0d expected 1", STATE);
    else checksPassed++;
    init = 1'b0;
    tick();
    checksTotal++;
    if (STATE !== 3'd2 || IDLE_OUT !== 1'b1)
      $display("[TB] FAIL state_idle: got %0d/%b expected 2/1", STATE, IDLE_OUT);
    else checksPassed++;
    checksTotal++;
    if (ALMOST_EMPTY_D !== 2'b11)
      $display("[TB] FAIL almost_empty_idle: got %b expected 11", ALMOST_EMPTY_D);
    else checksPassed++;
  endtask

  task automatic test_single_word();
    PUSH_MAIN = 1'b1; DATA_IN_TX = 6'h15;
    tick();
    PUSH_MAIN = 1'b0;
    tick();
    checksTotal++;
    if (STATE !== 3'd3 || EMPTY_D[1] !== 1'b1)
      $display("[TB] FAIL single_n1: got state %0d empty1 %b expected 3/1", STATE, EMPTY_D[1]);
    else checksPassed++;
    tick();
    checksTotal++;
    if (EMPTY_D !== 2'b01) $display("[TB] FAIL single_empty_n2: got %b expected 01", EMPTY_D);
    else checksPassed++;
    POP_D = 2'b10;
    tick();
    POP_D = 2'b00;
    checksTotal++;
    if (DATA_OUT_D[11:6] !== 6'h15 || VALID_D !== 2'b10)
      $display("[TB] FAIL single_pop: got %h/%b expected 15/10", DATA_OUT_D[11:6], VALID_D);
    else checksPassed++;
    tick();
    checksTotal++;
    if (STATE !== 3'd2 || VALID_D !== 2'b00 || EMPTY_D !== 2'b11)
      $display("[TB] FAIL single_back_idle: got %0d/%b/%b expected 2/00/11", STATE, VALID_D, EMPTY_D);
    else checksPassed++;
  endtask

  task automatic test_pause();
    vc_high = 8'h11; dest_high = 8'h11;
    reinit();
    for (int i = 0; i < 8; i++) begin
      PUSH_MAIN = 1'b1; DATA_IN_TX = 6'(i + 1);
      tick();
    end
    PUSH_MAIN = 1'b0;
    checksTotal++;
    if (MAIN_PAUSE !== 1'b0) $display("[TB] FAIL pause_below_high: got %b expected 0", MAIN_PAUSE);
    else checksPassed++;
    tick();
    checksTotal++;
    if (MAIN_PAUSE !== 1'b1) $display("[TB] FAIL pause_set: got %b expected 1", MAIN_PAUSE);
    else checksPassed++;
    for (int k = 0; k < 8; k++) begin
      POP_D = 2'b01;
      tick();
      POP_D = 2'b00;
      checksTotal++;
      if (VALID_D !== 2'b01 || DATA_OUT_D[5:0] !== 6'(k + 1))
        $display("[TB] FAIL pause_pop%0d: got %h/%b expected %h/01", k, DATA_OUT_D[5:0], VALID_D, 6'(k + 1));
      else checksPassed++;
      if (k == 4) begin
        checksTotal++;
        if (MAIN_PAUSE !== 1'b0) $display("[TB] FAIL pause_release: got %b expected 0", MAIN_PAUSE);
        else checksPassed++;
      end
      tick();
      tick();
      if (k <= 3) begin
        checksTotal++;
        if (MAIN_PAUSE !== 1'b1) $display("[TB] FAIL pause_hold%0d: got %b expected 1", k, MAIN_PAUSE);
        else checksPassed++;
      end
    end
    checksTotal++;
    if (STATE !== 3'd2 || EMPTY_D !== 2'b11)
      $display("[TB] FAIL pause_drained: got %0d/%b expected 2/11", STATE, EMPTY_D);
    else checksPassed++;
  endtask

  task automatic test_arbitration();
    logic [5:0] pushSeq  [5];
    logic [5:0] expOrder [5];
    pushSeq = '{6'h2F, 6'h01, 6'h03, 6'h21, 6'h23};
`ifdef TX_RR_ARB_EN
    expOrder = '{6'h2F, 6'h01, 6'h21, 6'h03, 6'h23};
`else
    expOrder = '{6'h2F, 6'h01, 6'h03, 6'h21, 6'h23};
`endif
    vc_high = 8'h44; dest_high = 8'h41;
    reinit();
    for (int i = 0; i < 5; i++) begin
      PUSH_MAIN = 1'b1; DATA_IN_TX = pushSeq[i];
      tick();
    end
    PUSH_MAIN = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 5; k++) begin
      POP_D = 2'b01;
      tick();
      POP_D = 2'b00;
      checksTotal++;
      if (VALID_D !== 2'b01 || DATA_OUT_D[5:0] !== expOrder[k])
        $display("[TB] FAIL arb_order%0d: got %h/%b expected %h/01", k, DATA_OUT_D[5:0], VALID_D, expOrder[k]);
      else checksPassed++;
      tick();
    end
  endtask

  task automatic test_pop_empty();
    tick();
    POP_D = 2'b01;
    tick();
    POP_D = 2'b00;
    checksTotal++;
    if (VALID_D !== 2'b00 || DATA_OUT_D[5:0] !== 6'h23)
      $display("[TB] FAIL pop_empty: got %h/%b expected 23/00", DATA_OUT_D[5:0], VALID_D);
    else checksPassed++;
    checksTotal++;
    if (ERROR_OUT !== 1'b0 || STATE !== 3'd2)
      $display("[TB] FAIL pop_empty_noerr: got %b/%0d expected 0/2", ERROR_OUT, STATE);
    else checksPassed++;
  endtask

  task automatic test_overflow();
    vc_high = 8'h00; dest_high = 8'h44;
    reinit();
    for (int i = 0; i < 8; i++) begin
      PUSH_MAIN = 1'b1; DATA_IN_TX = 6'(i);
      tick();
    end
    checksTotal++;
    if (ERROR_OUT !== 1'b0 || STATE !== 3'd3)
      $display("[TB] FAIL ovf_full_ok: got %b/%0d expected 0/3", ERROR_OUT, STATE);
    else checksPassed++;
    DATA_IN_TX = 6'h3F;
    tick();
    checksTotal++;
    if (ERROR_OUT !== 1'b1 || STATE !== 3'd4)
      $display("[TB] FAIL ovf_error: got %b/%0d expected 1/4", ERROR_OUT, STATE);
    else checksPassed++;
    tick();
    PUSH_MAIN = 1'b0;
    tick();
    checksTotal++;
    if (ERROR_OUT !== 1'b1 || STATE !== 3'd4 || EMPTY_D !== 2'b11 || MAIN_PAUSE !== 1'b1)
      $display("[TB] FAIL ovf_sticky: got %b/%0d/%b/%b expected 1/4/11/1", ERROR_OUT, STATE, EMPTY_D, MAIN_PAUSE);
    else checksPassed++;
    @(negedge clk);
    RESET_L = 1'b0;
    #1;
    checksTotal++;
    if (STATE !== 3'd0 || ERROR_OUT !== 1'b0 || MAIN_PAUSE !== 1'b0 || EMPTY_D !== 2'b11 || VALID_D !== 2'b00)
      $display("[TB] FAIL ovf_reset: got %0d/%b/%b/%b/%b expected 0/0/0/11/00",
               STATE, ERROR_OUT, MAIN_PAUSE, EMPTY_D, VALID_D);
    else checksPassed++;
    checksTotal++;
    if (DATA_OUT_D !== 12'h000) $display("[TB] FAIL ovf_reset_data: got %h expected 000", DATA_OUT_D);
    else checksPassed++;
    @(negedge clk);
    RESET_L = 1'b1;
    tick();
    checksTotal++;
    if (STATE !== 3'd1) $display("[TB] FAIL ovf_recover: got %0d expected 1", STATE);
    else checksPassed++;
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_single_word();
    test_pause();
    test_arbitration();
    test_pop_empty();
    test_overflow();
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
